// File: rtl/vec_mul_seq_ctrl.sv
// vec_mul_seq_ctrl: sequences one vector-multiply job.
// It pops a weight tile, pulses the multiplier weight reload, and streams
// num_vec reads from the unified buffer. Each read is written back into the
// results SRAM PIPE_LATENCY cycles later. All outputs come straight from flops.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; job parameters latched on accept
// S_WLOAD  | waiting for a weight tile; pop it once the FIFO is non-empty
// S_RELOAD | one-cycle weight reload pulse into the multiplier
// S_STREAM | one UB read per cycle, num_vec reads in total
// S_DRAIN  | reads finished; waiting for the write-back pipe to empty
// S_DONE   | one-cycle end_ pulse, then back to idle
module vec_mul_seq_ctrl #(
  parameter int ADDRESSSIZE  = 10,
  parameter int PIPE_LATENCY = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_start,
  input  logic [ADDRESSSIZE-1:0] i_num_vec,
  input  logic [ADDRESSSIZE-1:0] i_src_base,
  input  logic [ADDRESSSIZE-1:0] i_dst_base,
  input  logic                   i_fifo_empty,
  output logic                   o_fifo_read_enable,
  output logic                   o_weight_reload,
  output logic                   o_ub_read_en,
  output logic [ADDRESSSIZE-1:0] o_ub_address,
  output logic                   o_res_write_enable,
  output logic [ADDRESSSIZE-1:0] o_res_address,
  output logic                   o_busy,
  output logic                   o_end_
);

  localparam logic [ADDRESSSIZE-1:0] L_ONE  = ADDRESSSIZE'(1);
  localparam logic [ADDRESSSIZE-1:0] L_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WLOAD  = 3'd1,
    S_RELOAD = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [ADDRESSSIZE-1:0]  r_num;
  logic [ADDRESSSIZE-1:0]  r_src;
  logic [ADDRESSSIZE-1:0]  r_dst;
  logic [ADDRESSSIZE-1:0]  r_rd_left;
  logic [ADDRESSSIZE-1:0]  r_wr_cnt;

  logic                    r_fifo_rd;
  logic                    r_reload;
  logic                    r_ub_en;
  logic [ADDRESSSIZE-1:0]  r_ub_addr;
  logic [PIPE_LATENCY-1:0] r_vld_sr;
  logic [ADDRESSSIZE-1:0]  r_res_addr;
  logic                    r_busy;
  logic                    r_end;

  logic                    w_accept;
  logic                    w_fifo_rd_nxt;
  logic                    w_reload_nxt;
  logic                    w_ub_en_nxt;
  logic [ADDRESSSIZE-1:0]  w_ub_addr_nxt;
  logic [ADDRESSSIZE-1:0]  w_rd_left_nxt;
  logic [PIPE_LATENCY:0]   w_vld_chain;
  logic                    w_we_nxt;

  // Read strobe delay line; bit PIPE_LATENCY-1 is the write strobe, and the
  // bit below it (or the read strobe itself for latency 1) is next cycle's write.
  assign w_vld_chain = {r_vld_sr, r_ub_en};
  assign w_we_nxt    = w_vld_chain[PIPE_LATENCY-1];

  // Next-state and next-output decode; everything defaults to idle/hold.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_fifo_rd_nxt = 1'b0;
    w_reload_nxt  = 1'b0;
    w_ub_en_nxt   = 1'b0;
    w_ub_addr_nxt = r_ub_addr;
    w_rd_left_nxt = r_rd_left;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          if (i_num_vec == L_ZERO) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt   = S_WLOAD;
            w_fifo_rd_nxt = ~i_fifo_empty;
          end
        end
      end
      S_WLOAD: begin
        // The pop is registered, so it is issued one cycle after a non-empty
        // flag is seen; the cycle after the pop moves on to the reload.
        if (r_fifo_rd) begin
          w_state_nxt  = S_RELOAD;
          w_reload_nxt = 1'b1;
        end else if (!i_fifo_empty) begin
          w_fifo_rd_nxt = 1'b1;
        end
      end
      S_RELOAD: begin
        w_state_nxt   = S_STREAM;
        w_ub_en_nxt   = 1'b1;
        w_ub_addr_nxt = r_src;
        w_rd_left_nxt = r_num - L_ONE;
      end
      S_STREAM: begin
        if (r_rd_left != L_ZERO) begin
          w_ub_en_nxt   = 1'b1;
          w_ub_addr_nxt = r_ub_addr + L_ONE;
          w_rd_left_nxt = r_rd_left - L_ONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_vld_sr == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and registered control outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_fifo_rd <= 1'b0;
      r_reload  <= 1'b0;
      r_ub_en   <= 1'b0;
      r_ub_addr <= '0;
      r_rd_left <= '0;
      r_busy    <= 1'b0;
      r_end     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fifo_rd <= w_fifo_rd_nxt;
      r_reload  <= w_reload_nxt;
      r_ub_en   <= w_ub_en_nxt;
      r_ub_addr <= w_ub_addr_nxt;
      r_rd_left <= w_rd_left_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_end     <= (w_state_nxt == S_DONE);
    end
  end

  // Job parameters captured when a start is accepted.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_num <= '0;
      r_src <= '0;
      r_dst <= '0;
    end else if (w_accept) begin
      r_num <= i_num_vec;
      r_src <= i_src_base;
      r_dst <= i_dst_base;
    end
  end

  // Write-back: delayed read strobe, write counter and destination address.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_vld_sr   <= '0;
      r_wr_cnt   <= '0;
      r_res_addr <= '0;
    end else begin
      r_vld_sr <= w_vld_chain[PIPE_LATENCY-1:0];
      if (w_accept) begin
        r_wr_cnt <= '0;
      end else if (w_we_nxt) begin
        r_wr_cnt <= r_wr_cnt + L_ONE;
      end
      if (w_we_nxt) begin
        r_res_addr <= r_dst + r_wr_cnt;
      end
    end
  end

  assign o_fifo_read_enable = r_fifo_rd;
  assign o_weight_reload    = r_reload;
  assign o_ub_read_en       = r_ub_en;
  assign o_ub_address       = r_ub_addr;
  assign o_res_write_enable = r_vld_sr[PIPE_LATENCY-1];
  assign o_res_address      = r_res_addr;
  assign o_busy             = r_busy;
  assign o_end_             = r_end;

endmodule
